puf_challenge_sequencer: RTL and testbench

Control stage that drives the arbiter PUF and collects its output. Generates a pseudo-random challenge sequence from an internal LFSR, fires one launch pulse per challenge, samples the single-bit PUF response through a synchroniser, and packs RESP_W responses into a word. The word is handed downstream over a valid/ready handshake. The block sits directly upstream of the PUF's challenge/pulse inputs and directly downstream of its response output.

---
 rtl/puf_challenge_sequencer_pkg.sv | 23 ++
 rtl/puf_challenge_sequencer_lfsr.sv | 33 +++
 rtl/puf_challenge_sequencer.sv | 171 +++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
// Holds the FSM state encoding, the LFSR feedback taps and the seed constants.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RELAX  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Feedback taps at bits 7, 5, 4 and 3: x^8 + x^6 + x^5 + x^4 + 1, period 255.
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED  = 8'hA5;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_lfsr.sv
// 8-bit Fibonacci LFSR that produces the PUF challenge sequence.
// A zero load value is replaced so the register can never lock up at all-zeros.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_step,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    // LFSR register: reset to SEED, load has priority over step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 8'h00) ? ZERO_SEED_SUB : i_seed;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives an arbiter PUF: LFSR challenges, timed launch pulses, synchronised
// response sampling and packing of RESP_W responses into a handshaked word.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int         CHAL_W = 8,
    parameter int         RESP_W = 8,
    parameter int         SETTLE = 4,
    parameter logic [7:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] chal_out,
    output logic              pulse_out,
    input  logic              resp_in,
    output logic [RESP_W-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int CNT_W = 6;
    localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_tmr;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_sync;
    logic [RESP_W-1:0]   r_word;
    logic                r_pulse;
    logic                r_valid;
    logic                r_busy;
    logic                w_tmr_done;
    logic                w_lfsr_load;
    logic                w_lfsr_step;

    assign w_tmr_done = (r_tmr == TMR_W'(SETTLE - 1));

    puf_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_lfsr_load),
        .i_seed  (seed),
        .i_step  (w_lfsr_step),
        .o_state (chal_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus LFSR load/step strobes
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_load = 1'b0;
        w_lfsr_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (seed_load) begin
                    w_lfsr_load = 1'b1;
                end else if (start) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_FIRE;
                end else begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_FIRE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt = ST_RELAX;
            end
            ST_RELAX: begin
                if (w_tmr_done) begin
                    w_lfsr_step = 1'b1;
                    // r_cnt was already bumped in SAMPLE for this bit
                    if (r_cnt == CNT_W'(RESP_W)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ARM;
                    end
                end else begin
                    w_state_nxt = ST_RELAX;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, idle outside timed phases
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmr <= '0;
        end else if ((r_state == ST_ARM) || (r_state == ST_FIRE) || (r_state == ST_RELAX)) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end else begin
            r_tmr <= '0;
        end
    end

    // Synchroniser, response packer, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_word  <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], resp_in};
            case (r_state)
                ST_IDLE: begin
                    r_word <= '0;
                    r_cnt  <= '0;
                end
                ST_SAMPLE: begin
                    r_word <= {r_word[RESP_W-2:0], r_sync[1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_word <= r_word;
                    r_cnt  <= r_cnt;
                end
            endcase
            // Outputs decoded from the upcoming state so they align with it
            r_pulse <= (w_state_nxt == ST_FIRE) || (w_state_nxt == ST_SAMPLE);
            r_valid <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign pulse_out  = r_pulse;
    assign resp_word  = r_word;
    assign resp_valid = r_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomised directed bench for puf_challenge_sequencer against a behavioural
// model of the LFSR sequence, pulse timing and MSB-first response packing.
module tb_puf_challenge_sequencer;

    localparam int RW = 8;
    localparam int ST = 4;
    localparam int BIT_CYC = 3 * ST + 1;
    localparam int VALID_CYC = 1 + RW * BIT_CYC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          seed_load = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic [7:0]    chal_out;
    logic          pulse_out;
    logic          resp_in;
    logic [RW-1:0] resp_word;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          busy;
    logic [7:0]    resp_mask = 8'h00;

    logic          s2_start = 1'b0;
    logic [7:0]    s2_chal;
    logic          s2_pulse;
    logic [1:0]    s2_word;
    logic          s2_valid;
    logic          s2_ready = 1'b0;
    logic          s2_busy;

    int total = 0;
    int bad = 0;
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    // PUF model: response is the parity of the challenge under a per-word mask
    assign resp_in = ^(chal_out ^ resp_mask);

    puf_challenge_sequencer #(.CHAL_W(8), .RESP_W(RW), .SETTLE(ST), .SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .chal_out(chal_out), .pulse_out(pulse_out), .resp_in(resp_in),
        .resp_word(resp_word), .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
    );

    puf_challenge_sequencer #(.CHAL_W(8), .RESP_W(2), .SETTLE(2), .SEED(8'hA5)) dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .seed_load(1'b0), .seed(8'h00),
        .chal_out(s2_chal), .pulse_out(s2_pulse), .resp_in(1'b1),
        .resp_word(s2_word), .resp_valid(s2_valid), .resp_ready(s2_ready), .busy(s2_busy)
    );

    function automatic logic [7:0] model_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full word: start, watch pulses/challenges, back-pressure, handshake
    task automatic run_word(input int bp_cycles, input bit noisy);
        logic [7:0]    exp_chal [RW];
        logic [7:0]    seen [RW];
        logic [RW-1:0] exp_word;
        logic [7:0]    c;
        logic [7:0]    prev_chal;
        logic          prev_pulse;
        int npulse, width, badw, moved, vcyc, held_bad, busy_bad;

        resp_mask = 8'($urandom);
        c = m_lfsr;
        exp_word = '0;
        for (int i = 0; i < RW; i++) begin
            exp_chal[i] = c;
            seen[i] = 8'h00;
            exp_word = {exp_word[RW-2:0], ^(c ^ resp_mask)};
            c = model_next(c);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("first_chal", {24'd0, chal_out}, {24'd0, exp_chal[0]});

        npulse = 0; width = 0; badw = 0; moved = 0; vcyc = 0; busy_bad = 0;
        prev_pulse = 1'b0;
        prev_chal = chal_out;
        for (int cyc = 1; cyc <= 4 * VALID_CYC; cyc++) begin
            if (resp_valid) begin
                vcyc = cyc;
                break;
            end
            if (!busy) busy_bad++;
            if (pulse_out) begin
                if (!prev_pulse) begin
                    if (npulse < RW) seen[npulse] = chal_out;
                    npulse++;
                    width = 0;
                end
                width++;
                if (chal_out != prev_chal) moved++;
            end else if (prev_pulse) begin
                if (width != ST + 1) badw++;
            end else begin
                width = 0;
            end
            prev_pulse = pulse_out;
            prev_chal = chal_out;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                seed_load = ($urandom_range(0, 3) == 0);
                seed = 8'($urandom);
            end
            tick();
        end
        start = 1'b0;
        seed_load = 1'b0;

        chk("valid_cycle", vcyc, VALID_CYC);
        chk("pulse_count", npulse, RW);
        chk("pulse_width_errs", badw, 0);
        chk("chal_moved_in_pulse", moved, 0);
        chk("busy_dropped", busy_bad, 0);
        for (int i = 0; i < RW; i++) begin
            chk($sformatf("chal_%0d", i), {24'd0, seen[i]}, {24'd0, exp_chal[i]});
        end
        chk("resp_word", 32'(resp_word), 32'(exp_word));

        held_bad = 0;
        for (int k = 0; k < bp_cycles; k++) begin
            if (noisy) start = 1'($urandom_range(0, 1));
            tick();
            if (!resp_valid || !busy || resp_word != exp_word) held_bad++;
        end
        chk("backpressure_hold", held_bad, 0);

        resp_ready = 1'b1;
        start = noisy;
        tick();
        resp_ready = 1'b0;
        start = 1'b0;
        chk("idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick();
        chk("no_restart", {30'd0, busy, resp_valid}, 32'd0);
        chk("chal_after_word", {24'd0, chal_out}, {24'd0, c});
        m_lfsr = c;
    endtask

    initial begin
        int s2c;
        logic [7:0] rs;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_lfsr = 8'hA5;
        chk("rst_chal", {24'd0, chal_out}, 32'h0000_00A5);
        chk("rst_out", {28'd0, pulse_out, resp_valid, busy, |resp_word}, 32'd0);

        run_word(0, 1'b0);
        run_word(50, 1'b0);
        run_word(int'($urandom_range(1, 20)), 1'b1);

        seed = 8'h00; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("zero_seed", {24'd0, chal_out}, 32'h0000_0001);
        m_lfsr = 8'h01;

        rs = 8'($urandom_range(1, 255));
        seed = rs; seed_load = 1'b1; start = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("seed_and_start_seed", {24'd0, chal_out}, {24'd0, rs});
        chk("seed_and_start_idle", {31'd0, busy}, 32'd0);
        m_lfsr = rs;
        run_word(int'($urandom_range(0, 10)), 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && !pulse_out; k++) tick();
        chk("reached_fire", {31'd0, pulse_out}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out", {29'd0, pulse_out, busy, |resp_word}, 32'd0);
        chk("midrst_chal", {24'd0, chal_out}, 32'h0000_00A5);
        m_lfsr = 8'hA5;
        run_word(2, 1'b0);

        s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        s2c = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (s2_valid) begin
                s2c = cyc;
                break;
            end
            tick();
        end
        chk("sweep_valid_cycle", s2c, 15);
        chk("sweep_word", {30'd0, s2_word}, 32'd3);
        s2_ready = 1'b1;
        tick();
        s2_ready = 1'b0;
        chk("sweep_idle", {31'd0, s2_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
